// File: rtl/wb_epbuf_arb_pkg.sv
// rtl/wb_epbuf_arb_pkg.sv - shared state encoding and requester indices for the EP-buffer arbiter
package wb_epbuf_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    localparam logic RQ_CPU = 1'b0;
    localparam logic RQ_DMA = 1'b1;

endpackage

// File: rtl/wb_epbuf_arb_rr_arb2.sv
// rtl/wb_epbuf_arb_rr_arb2.sv - combinational 2-way round-robin pick (lock-aware with WB_EPBUF_ARB_LOCK_EN)
module rr_arb2
    import wb_epbuf_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
`ifdef WB_EPBUF_ARB_LOCK_EN
    input  logic       lock_valid,
    input  logic       lock_owner,
`endif
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic [1:0] eff_req;

    // Mask out the non-owner while a lock is held, then alternate on a tie
    always_comb begin
        eff_req   = req;
`ifdef WB_EPBUF_ARB_LOCK_EN
        if (lock_valid) begin
            eff_req = req & (lock_owner ? 2'b10 : 2'b01);
        end
`endif
        gnt_valid = |eff_req;
        gnt_idx   = (eff_req == 2'b11) ? ~last : eff_req[RQ_DMA];
    end

endmodule

// File: rtl/wb_epbuf_arb.sv
// rtl/wb_epbuf_arb.sv - two-requester EP-buffer access arbiter, optional lock via WB_EPBUF_ARB_LOCK_EN
module wb_epbuf_arb #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rq0_req,
    input  logic          rq0_we,
    input  logic [AW-1:0] rq0_addr,
    input  logic [DW-1:0] rq0_wdata,
    input  logic          rq0_lock,
    output logic          rq0_ack,
    output logic [DW-1:0] rq0_rdata,
    input  logic          rq1_req,
    input  logic          rq1_we,
    input  logic [AW-1:0] rq1_addr,
    input  logic [DW-1:0] rq1_wdata,
    input  logic          rq1_lock,
    output logic          rq1_ack,
    output logic [DW-1:0] rq1_rdata,
    output logic [AW-1:0] ep_tx_addr_0,
    output logic [DW-1:0] ep_tx_data_0,
    output logic          ep_tx_we_0,
    output logic [AW-1:0] ep_rx_addr_0,
    input  logic [DW-1:0] ep_rx_data_1,
    output logic          ep_rx_re_0,
    output logic          arb_busy
);
    import wb_epbuf_arb_pkg::*;

    state_t state;
    logic   sel;
    logic   last;
    logic   rd_ack;
    logic   gnt_valid;
    logic   gnt_idx;

`ifdef WB_EPBUF_ARB_LOCK_EN
    logic   lock_valid;
    logic   lock_owner;
    logic   sel_lock;

    assign sel_lock = (sel == RQ_DMA) ? rq1_lock : rq0_lock;

    // Lock ownership is decided by the lock bit of the access completing in ACK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_valid <= 1'b0;
            lock_owner <= RQ_CPU;
        end else if (state == ST_ACK) begin
            lock_valid <= sel_lock;
            if (sel_lock) begin
                lock_owner <= sel;
            end
        end
    end
`else
    logic   unused_lock;

    assign unused_lock = rq0_lock ^ rq1_lock;
`endif

    rr_arb2 u_rr_arb2 (
        .req        ({rq1_req, rq0_req}),
        .last       (last),
`ifdef WB_EPBUF_ARB_LOCK_EN
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
`endif
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // Select -> issue -> ack sequencer; strobes and acks are single-cycle registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sel          <= RQ_CPU;
            last         <= RQ_DMA;
            ep_tx_addr_0 <= '0;
            ep_tx_data_0 <= '0;
            ep_rx_addr_0 <= '0;
            ep_tx_we_0   <= 1'b0;
            ep_rx_re_0   <= 1'b0;
            rq0_ack      <= 1'b0;
            rq1_ack      <= 1'b0;
            rd_ack       <= 1'b0;
        end else begin
            ep_tx_we_0 <= 1'b0;
            ep_rx_re_0 <= 1'b0;
            rq0_ack    <= 1'b0;
            rq1_ack    <= 1'b0;
            rd_ack     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        sel          <= gnt_idx;
                        last         <= gnt_idx;
                        ep_tx_addr_0 <= (gnt_idx == RQ_DMA) ? rq1_addr  : rq0_addr;
                        ep_rx_addr_0 <= (gnt_idx == RQ_DMA) ? rq1_addr  : rq0_addr;
                        ep_tx_data_0 <= (gnt_idx == RQ_DMA) ? rq1_wdata : rq0_wdata;
                        ep_tx_we_0   <= (gnt_idx == RQ_DMA) ? rq1_we    : rq0_we;
                        ep_rx_re_0   <= (gnt_idx == RQ_DMA) ? ~rq1_we   : ~rq0_we;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rq0_ack <= (sel == RQ_CPU);
                    rq1_ack <= (sel == RQ_DMA);
                    rd_ack  <= ep_rx_re_0;
                    state   <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data arrives one cycle after the ISSUE address, i.e. during ACK
    assign rq0_rdata = (rq0_ack && rd_ack) ? ep_rx_data_1 : '0;
    assign rq1_rdata = (rq1_ack && rd_ack) ? ep_rx_data_1 : '0;
    assign arb_busy  = (state != ST_IDLE);

endmodule
